// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    localparam logic [31:0] UART_TXDATA_OFS = 32'd0;
    localparam logic [31:0] UART_STATUS_OFS = 32'd4;

    localparam int ST_FULL_BIT  = 0;
    localparam int ST_EMPTY_BIT = 1;
    localparam int ST_BUSY_BIT  = 2;
    localparam int ST_OVF_BIT   = 3;
    localparam int ST_COUNT_LSB = 8;

    // Assemble the STATUS word; unused bits read as zero.
    function automatic logic [31:0] pack_status(input logic full, input logic empty,
                                                input logic busy, input logic ovf,
                                                input logic [7:0] count);
        logic [31:0] s;
        s = 32'h0000_0000;
        s[ST_FULL_BIT]                  = full;
        s[ST_EMPTY_BIT]                 = empty;
        s[ST_BUSY_BIT]                  = busy;
        s[ST_OVF_BIT]                   = ovf;
        s[ST_COUNT_LSB +: 8]            = count;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data. Pointers wrap modulo DEPTH.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    import uart_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;
    logic             full_s;
    logic             empty_s;

    // Flag decode and acceptance of push/pop requests.
    always_comb begin
        full_s    = (count_r == CW'(DEPTH));
        empty_s   = (count_r == {CW{1'b0}});
        pop_ok_s  = pop & ~empty_s;
        push_ok_s = push & (~full_s | pop_ok_s);
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign pop_data = mem_r[rd_ptr_r];
    assign full     = full_s;
    assign empty    = empty_s;
    assign count    = count_r;

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: stores to TXDATA queue bytes, an FSM
// serialises them LSB first on tx, and STATUS is readable on the load port.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic [3:0]  byte_en,
    input  logic [31:0] rd_addr,
    output logic [31:0] rd_data,
    output logic        rd_hit,
    output logic        tx,
    output logic        busy
);
    import uart_pkg::*;

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [31:0] TXDATA_ADDR = BASE_ADDR + UART_TXDATA_OFS;
    localparam logic [31:0] STATUS_ADDR = BASE_ADDR + UART_STATUS_OFS;
    localparam logic [29:0] TXDATA_WORD = TXDATA_ADDR[31:2];
    localparam logic [29:0] STATUS_WORD = STATUS_ADDR[31:2];

    uart_tx_state_t state_r;
    logic [7:0]     shift_r;
    logic [2:0]     bit_cnt_r;
    logic [BW-1:0]  baud_cnt_r;
    logic           tx_r;
    logic           busy_r;
    logic           ovf_r;

    logic           push_req_s;
    logic           ovf_clr_s;
    logic           ovf_set_s;
    logic           baud_end_s;
    logic           pop_s;
    logic [7:0]     fifo_data_s;
    logic           fifo_full_s;
    logic           fifo_empty_s;
    logic [CW-1:0]  fifo_count_s;
    logic [31:0]    status_s;
    logic           rd_hit_s;

    // Store decode, overflow detection and the pop request from the serialiser.
    always_comb begin
        push_req_s = wr_en & byte_en[0] & (wr_addr[31:2] == TXDATA_WORD);
        ovf_clr_s  = wr_en & byte_en[0] & (wr_addr[31:2] == STATUS_WORD) & wr_data[ST_OVF_BIT];
        baud_end_s = (baud_cnt_r == BW'(CLKS_PER_BIT - 1));
        if (state_r == IDLE) begin
            pop_s = ~fifo_empty_s;
        end else if (state_r == STOP) begin
            pop_s = ~fifo_empty_s & baud_end_s;
        end else begin
            pop_s = 1'b0;
        end
        ovf_set_s  = push_req_s & fifo_full_s & ~pop_s;
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_req_s),
        .push_data (wr_data[7:0]),
        .pop       (pop_s),
        .pop_data  (fifo_data_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // Sticky overflow flag; a new drop wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (ovf_set_s) begin
            ovf_r <= 1'b1;
        end else if (ovf_clr_s) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    // Busy is registered so a store never reaches it combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_r != IDLE) | ~fifo_empty_s;
        end
    end

    // Serialiser FSM with baud counter; tx is registered from the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            shift_r    <= 8'h00;
            bit_cnt_r  <= 3'd0;
            baud_cnt_r <= {BW{1'b0}};
            tx_r       <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    tx_r <= 1'b1;
                    if (!fifo_empty_s) begin
                        shift_r    <= fifo_data_s;
                        bit_cnt_r  <= 3'd0;
                        baud_cnt_r <= {BW{1'b0}};
                        state_r    <= START;
                    end
                end
                START: begin
                    tx_r <= 1'b0;
                    if (baud_end_s) begin
                        baud_cnt_r <= {BW{1'b0}};
                        state_r    <= DATA;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BW'(1);
                    end
                end
                DATA: begin
                    tx_r <= shift_r[0];
                    if (baud_end_s) begin
                        baud_cnt_r <= {BW{1'b0}};
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= STOP;
                        end else begin
                            shift_r   <= {1'b0, shift_r[7:1]};
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BW'(1);
                    end
                end
                STOP: begin
                    tx_r <= 1'b1;
                    if (baud_end_s) begin
                        baud_cnt_r <= {BW{1'b0}};
                        if (!fifo_empty_s) begin
                            shift_r   <= fifo_data_s;
                            bit_cnt_r <= 3'd0;
                            state_r   <= START;
                        end else begin
                            state_r   <= IDLE;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BW'(1);
                    end
                end
                default: begin
                    tx_r       <= 1'b1;
                    baud_cnt_r <= {BW{1'b0}};
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    // STATUS assembly and load-port decode.
    always_comb begin
        status_s = pack_status(fifo_full_s, fifo_empty_s, busy_r, ovf_r, 8'(fifo_count_s));
        rd_hit_s = (rd_addr[31:2] == STATUS_WORD);
        if (rd_hit_s) begin
            rd_data = status_s;
        end else begin
            rd_data = 32'h0000_0000;
        end
    end

    assign rd_hit = rd_hit_s;
    assign tx     = tx_r;
    assign busy   = busy_r;

endmodule
